// File: rtl/nn_pkg.sv
// Shared definitions for the classifier-core feeder: FSM encoding, frame geometry,
// class width and the sentinel class reported when the core never answers.
package nn_pkg;

  localparam int unsigned NN_N_IN      = 784;
  localparam int unsigned NN_ADDR_W    = 10;
  localparam int unsigned NN_CLASS_W   = 4;

  localparam logic [NN_CLASS_W-1:0] NN_CLASS_TIMEOUT = 4'hF;

  typedef enum logic [2:0] {
    StLoad,
    StFlush,
    StKick,
    StWait,
    StRelease,
    StResult
  } nn_state_e;

endpackage

// File: rtl/nn_feeder_if.sv
// Bundle of the feeder's pixel stream, core write/start/done and result channels.
// Optional r_cycles member exists only when NN_FEEDER_CYCLE_COUNT_EN is defined.
interface nn_feeder_if #(
  parameter int unsigned ADDR_W = nn_pkg::NN_ADDR_W
);

  logic                              s_valid;
  logic                              s_ready;
  logic [7:0]                        s_data;
  logic                              s_last;
  logic                              pix_we;
  logic [ADDR_W-1:0]                 pix_addr;
  logic [7:0]                        pix_data;
  logic                              nn_start;
  logic                              nn_done;
  logic [nn_pkg::NN_CLASS_W-1:0]     nn_predicted;
  logic                              r_valid;
  logic                              r_ready;
  logic [nn_pkg::NN_CLASS_W-1:0]     r_class;
  logic                              r_err;
  logic                              busy;
`ifdef NN_FEEDER_CYCLE_COUNT_EN
  logic [31:0]                       r_cycles;
`endif

  // Feeder side.
  modport master (
    input  s_valid, s_data, s_last, nn_done, nn_predicted, r_ready,
    output s_ready, pix_we, pix_addr, pix_data, nn_start, r_valid, r_class, r_err, busy
`ifdef NN_FEEDER_CYCLE_COUNT_EN
    , output r_cycles
`endif
  );

  // Environment side: stream source, core and result consumer.
  modport slave (
    output s_valid, s_data, s_last, nn_done, nn_predicted, r_ready,
    input  s_ready, pix_we, pix_addr, pix_data, nn_start, r_valid, r_class, r_err, busy
`ifdef NN_FEEDER_CYCLE_COUNT_EN
    , input r_cycles
`endif
  );

endinterface

// File: rtl/nn_feeder_timeout.sv
// Loadable down-counter: clr_i loads load_val_i, en_i decrements toward zero,
// expire_o flags that the loaded budget has been used up.
module nn_feeder_timeout #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic             expire_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  assign expire_o = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = load_val_i;
    end else if (en_i && !expire_o) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/nn_feeder.sv
// Streams one frame into the classifier core, runs one inference and returns the class.
// Optional WAIT-cycle counter on r_cycles is built when NN_FEEDER_CYCLE_COUNT_EN is defined.
module nn_feeder
  import nn_pkg::*;
#(
  parameter int unsigned N_IN    = NN_N_IN,
  parameter int unsigned ADDR_W  = NN_ADDR_W,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic         clk,
  input  logic         rst,
  nn_feeder_if.master  bus
);

  localparam int unsigned CntW = $clog2(N_IN + 1);
  localparam int unsigned ToW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CntW-1:0] NInC   = CntW'(N_IN);
  localparam logic [CntW-1:0] NInM1  = CntW'(N_IN - 1);
  localparam logic [ToW-1:0]  ToLoad = ToW'(TIMEOUT - 1);

  nn_state_e               state_q, state_d;
  logic [CntW-1:0]         count_q, count_d;
  logic                    err_q, err_d;
  logic [NN_CLASS_W-1:0]   r_class_q, r_class_d;
  logic                    nn_start_q, nn_start_d;
  logic                    pix_we_q, pix_we_d;
  logic [ADDR_W-1:0]       pix_addr_q, pix_addr_d;
  logic [7:0]              pix_data_q, pix_data_d;
  logic                    to_clr, to_en, to_expire;

`ifdef NN_FEEDER_CYCLE_COUNT_EN
  logic [31:0] cyc_q, cyc_d, r_cycles_q, r_cycles_d, cyc_inc;
  assign cyc_inc = (&cyc_q) ? cyc_q : cyc_q + 32'd1;
`endif

  nn_feeder_timeout #(
    .WIDTH (ToW)
  ) u_timeout (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (to_clr),
    .load_val_i (ToLoad),
    .en_i       (to_en),
    .expire_o   (to_expire)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    err_d      = err_q;
    r_class_d  = r_class_q;
    nn_start_d = nn_start_q;
    pix_we_d   = 1'b0;
    pix_addr_d = pix_addr_q;
    pix_data_d = pix_data_q;
    to_clr     = 1'b0;
    to_en      = 1'b0;
`ifdef NN_FEEDER_CYCLE_COUNT_EN
    cyc_d      = cyc_q;
    r_cycles_d = r_cycles_q;
`endif

    unique case (state_q)
      StLoad: begin
        if (bus.s_valid) begin
          // Overflow bytes are swallowed so the source never stalls mid-frame.
          if (count_q < NInC) begin
            pix_we_d   = 1'b1;
            pix_addr_d = ADDR_W'(count_q);
            pix_data_d = bus.s_data;
            count_d    = count_q + CntW'(1);
          end else begin
            err_d = 1'b1;
          end
          if (bus.s_last) begin
            if (count_q < NInM1) begin
              err_d = 1'b1;
            end
            state_d = StFlush;
          end
        end
      end

      StFlush: state_d = StKick;

      StKick: begin
        nn_start_d = 1'b1;
        to_clr     = 1'b1;
`ifdef NN_FEEDER_CYCLE_COUNT_EN
        cyc_d      = '0;
`endif
        state_d    = StWait;
      end

      StWait: begin
`ifdef NN_FEEDER_CYCLE_COUNT_EN
        cyc_d = cyc_inc;
`endif
        if (bus.nn_done) begin
          r_class_d  = bus.nn_predicted;
          nn_start_d = 1'b0;
          state_d    = StRelease;
`ifdef NN_FEEDER_CYCLE_COUNT_EN
          r_cycles_d = cyc_inc;
`endif
        end else if (to_expire) begin
          r_class_d  = NN_CLASS_TIMEOUT;
          err_d      = 1'b1;
          nn_start_d = 1'b0;
          state_d    = StResult;
`ifdef NN_FEEDER_CYCLE_COUNT_EN
          r_cycles_d = cyc_inc;
`endif
        end else begin
          to_en = 1'b1;
        end
      end

      // Hold off the result until the core has seen start fall and dropped done.
      StRelease: begin
        if (!bus.nn_done) begin
          state_d = StResult;
        end
      end

      StResult: begin
        if (bus.r_ready) begin
          count_d = '0;
          err_d   = 1'b0;
          state_d = StLoad;
        end
      end

      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StLoad;
      count_q    <= '0;
      err_q      <= 1'b0;
      r_class_q  <= '0;
      nn_start_q <= 1'b0;
      pix_we_q   <= 1'b0;
      pix_addr_q <= '0;
      pix_data_q <= '0;
`ifdef NN_FEEDER_CYCLE_COUNT_EN
      cyc_q      <= '0;
      r_cycles_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      err_q      <= err_d;
      r_class_q  <= r_class_d;
      nn_start_q <= nn_start_d;
      pix_we_q   <= pix_we_d;
      pix_addr_q <= pix_addr_d;
      pix_data_q <= pix_data_d;
`ifdef NN_FEEDER_CYCLE_COUNT_EN
      cyc_q      <= cyc_d;
      r_cycles_q <= r_cycles_d;
`endif
    end
  end

  assign bus.s_ready  = (state_q == StLoad);
  assign bus.pix_we   = pix_we_q;
  assign bus.pix_addr = pix_addr_q;
  assign bus.pix_data = pix_data_q;
  assign bus.nn_start = nn_start_q;
  assign bus.r_valid  = (state_q == StResult);
  assign bus.r_class  = r_class_q;
  assign bus.r_err    = (state_q == StResult) & err_q;
  assign bus.busy     = !((state_q == StLoad) && (count_q == '0));
`ifdef NN_FEEDER_CYCLE_COUNT_EN
  assign bus.r_cycles = r_cycles_q;
`endif

endmodule

// File: tb/tb_nn_feeder.sv
// Directed bench for nn_feeder: full/short/long frames, result back-pressure,
// reset during inference and a TIMEOUT=16 instance whose core never answers.
module tb_nn_feeder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  nn_feeder_if #(.ADDR_W(10)) b ();
  nn_feeder_if #(.ADDR_W(10)) t ();

  nn_feeder #(.N_IN(784), .ADDR_W(10), .TIMEOUT(65535)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  nn_feeder #(.N_IN(784), .ADDR_W(10), .TIMEOUT(16)) u_dut_to (
    .clk (clk),
    .rst (rst),
    .bus (t)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write/accept/start monitor on the main instance.
  int         wr_cnt = 0;
  int         wr_bad = 0;
  int         acc_cnt = 0;
  int         start_rises = 0;
  logic [9:0] last_addr = '0;
  logic       start_prev = 1'b0;

  always @(negedge clk) begin
    if (b.pix_we) begin
      if (b.pix_addr !== wr_cnt[9:0] || b.pix_data !== wr_cnt[7:0]) wr_bad++;
      last_addr = b.pix_addr;
      wr_cnt++;
    end
    if (b.s_valid && b.s_ready) acc_cnt++;
    if (b.nn_start && !start_prev) start_rises++;
    start_prev = b.nn_start;
  end

  // Core model: raises done core_delay cycles after start rises, drops it when start falls.
  int         core_delay = 100;
  logic [3:0] core_class = 4'd0;
  bit         start_seen = 1'b0;

  initial begin
    b.nn_done = 1'b0;
    b.nn_predicted = 4'd0;
    forever begin
      @(negedge clk);
      if (b.nn_start && !start_seen) begin
        start_seen = 1'b1;
        repeat (core_delay - 1) @(negedge clk);
        b.nn_done = 1'b1;
        b.nn_predicted = core_class;
      end else if (!b.nn_start && start_seen) begin
        start_seen = 1'b0;
        b.nn_done = 1'b0;
      end
    end
  end

  task automatic clear_mon();
    wr_cnt = 0;
    wr_bad = 0;
    acc_cnt = 0;
    start_rises = 0;
  endtask

  // Byte i carries value i[7:0]; s_last on the final byte.
  task automatic send_frame(input int n);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 5000) begin
      @(negedge clk);
      if (b.s_ready) begin
        b.s_valid = 1'b1;
        b.s_data = i[7:0];
        b.s_last = (i == n - 1);
        i++;
      end else begin
        b.s_valid = 1'b0;
        guard++;
      end
    end
    @(negedge clk);
    b.s_valid = 1'b0;
    b.s_last = 1'b0;
    chk("send_done", 32'(i), 32'(n));
  endtask

  task automatic send_frame_t(input int n);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 5000) begin
      @(negedge clk);
      if (t.s_ready) begin
        t.s_valid = 1'b1;
        t.s_data = i[7:0];
        t.s_last = (i == n - 1);
        i++;
      end else begin
        t.s_valid = 1'b0;
        guard++;
      end
    end
    @(negedge clk);
    t.s_valid = 1'b0;
    t.s_last = 1'b0;
    chk("to_send_done", 32'(i), 32'(n));
  endtask

  task automatic wait_rvalid(input string tag);
    int k = 0;
    while (!b.r_valid && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(b.r_valid), 1);
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    b.r_ready = 1'b1;
    b.s_valid = 1'b0;
    @(negedge clk);
    b.r_ready = 1'b0;
    chk({tag, "_rvalid_low"}, 32'(b.r_valid), 0);
    chk({tag, "_s_ready"}, 32'(b.s_ready), 1);
    chk({tag, "_busy_idle"}, 32'(b.busy), 0);
  endtask

  initial begin
    int bp_bad;
    int k;
    int hi;

    b.s_valid = 1'b0; b.s_data = 8'd0; b.s_last = 1'b0; b.r_ready = 1'b0;
    t.s_valid = 1'b0; t.s_data = 8'd0; t.s_last = 1'b0; t.r_ready = 1'b0;
    t.nn_done = 1'b0; t.nn_predicted = 4'd0;

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", 32'(b.s_ready), 1);
    chk("rst_pix_we", 32'(b.pix_we), 0);
    chk("rst_nn_start", 32'(b.nn_start), 0);
    chk("rst_r_valid", 32'(b.r_valid), 0);
    chk("rst_r_err", 32'(b.r_err), 0);
    chk("rst_r_class", 32'(b.r_class), 0);
    chk("rst_busy", 32'(b.busy), 0);
    chk("rst_pix_addr", 32'(b.pix_addr), 0);
    rst = 1'b1;

    // Full frame, class 7
    core_delay = 100; core_class = 4'd7;
    clear_mon();
    send_frame(784);
    wait_rvalid("full_rvalid");
    chk("full_writes", 32'(wr_cnt), 784);
    chk("full_wr_bad", 32'(wr_bad), 0);
    chk("full_last_addr", 32'(last_addr), 783);
    chk("full_start_rises", 32'(start_rises), 1);
    chk("full_class", 32'(b.r_class), 7);
    chk("full_err", 32'(b.r_err), 0);

    // Back-pressure at RESULT with the next frame's first byte offered
    bp_bad = 0;
    acc_cnt = 0;
    b.s_valid = 1'b1; b.s_data = 8'h00; b.s_last = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (b.r_valid !== 1'b1 || b.r_class !== 4'd7 || b.r_err !== 1'b0 ||
          b.s_ready !== 1'b0 || b.pix_we !== 1'b0) bp_bad++;
    end
    chk("bp_stable", 32'(bp_bad), 0);
    chk("bp_no_accept", 32'(acc_cnt), 0);
    chk("bp_no_write", 32'(wr_cnt), 784);
    handshake("bp");

    // Short frame: 500 bytes, class 3
    core_class = 4'd3;
    clear_mon();
    send_frame(500);
    wait_rvalid("short_rvalid");
    chk("short_writes", 32'(wr_cnt), 500);
    chk("short_wr_bad", 32'(wr_bad), 0);
    chk("short_last_addr", 32'(last_addr), 499);
    chk("short_start_rises", 32'(start_rises), 1);
    chk("short_class", 32'(b.r_class), 3);
    chk("short_err", 32'(b.r_err), 1);
    handshake("short");

    // Long frame: 800 bytes, class 5
    core_class = 4'd5;
    clear_mon();
    send_frame(800);
    wait_rvalid("long_rvalid");
    chk("long_writes", 32'(wr_cnt), 784);
    chk("long_accepted", 32'(acc_cnt), 800);
    chk("long_wr_bad", 32'(wr_bad), 0);
    chk("long_last_addr", 32'(last_addr), 783);
    chk("long_class", 32'(b.r_class), 5);
    chk("long_err", 32'(b.r_err), 1);
    handshake("long");

    // Reset while waiting on the core
    core_class = 4'd9;
    clear_mon();
    send_frame(784);
    k = 0;
    while (!b.nn_start && k < 100) begin
      @(negedge clk);
      k++;
    end
    repeat (5) @(negedge clk);
    chk("wait_start_high", 32'(b.nn_start), 1);
    chk("wait_busy", 32'(b.busy), 1);
    rst = 1'b0;
    @(negedge clk);
    chk("rstw_nn_start", 32'(b.nn_start), 0);
    chk("rstw_r_valid", 32'(b.r_valid), 0);
    chk("rstw_s_ready", 32'(b.s_ready), 1);
    rst = 1'b1;

    // Recovery frame after reset, class 2
    core_class = 4'd2;
    clear_mon();
    send_frame(784);
    wait_rvalid("recov_rvalid");
    chk("recov_writes", 32'(wr_cnt), 784);
    chk("recov_wr_bad", 32'(wr_bad), 0);
    chk("recov_start_rises", 32'(start_rises), 1);
    chk("recov_class", 32'(b.r_class), 2);
    chk("recov_err", 32'(b.r_err), 0);
    handshake("recov");

    // Timeout instance: done never rises
    send_frame_t(784);
    k = 0;
    while (!t.nn_start && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("to_start_rose", 32'(t.nn_start), 1);
    hi = 0;
    while (t.nn_start && hi < 100) begin
      hi++;
      @(negedge clk);
    end
    chk("to_start_cycles", 32'(hi), 16);
    chk("to_r_valid", 32'(t.r_valid), 1);
    chk("to_r_class", 32'(t.r_class), 15);
    chk("to_r_err", 32'(t.r_err), 1);
    @(negedge clk);
    t.r_ready = 1'b1;
    @(negedge clk);
    t.r_ready = 1'b0;
    chk("to_rvalid_low", 32'(t.r_valid), 0);
    chk("to_s_ready", 32'(t.s_ready), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
